// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle MULT/DIV with HI/LO registers and MFHI/MFLO read-back.
// Define MDU_MADD_EN to add the MADD/MSUB accumulate ops; otherwise those encodings are no-ops.
module mdu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        MDUOp,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic [DATA_W-1:0] out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               cnt, cnt_nxt;
    logic                     load, done, accept, is_mul, is_div;
    logic signed [2*DATA_W-1:0] a_s, b_s, prod_s;
    logic [2*DATA_W-1:0]      prod_u;
    logic [2*DATA_W-1:0]      res_p0;
    logic                     vld_p0;
    logic [2*DATA_W-1:0]      pend_p1;
    logic                     vld_p1;

    // Returns {remainder, quotient}; a zero divisor is steered to 1 so the
    // divider never sees an undefined operand (the result is discarded anyway).
    function automatic logic [2*DATA_W-1:0] div_u(input logic [DATA_W-1:0] n,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] dd;
        dd = (d == '0) ? DATA_W'(1) : d;
        return {n % dd, n / dd};
    endfunction

    // Signed divide on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend, so MIN / -1 wraps to MIN with rem 0.
    function automatic logic [2*DATA_W-1:0] div_s(input logic [DATA_W-1:0] n,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0]   un, ud, q, r;
        logic [2*DATA_W-1:0] qr;
        un = n[DATA_W-1] ? -n : n;
        ud = d[DATA_W-1] ? -d : d;
        qr = div_u(un, ud);
        q  = qr[DATA_W-1:0];
        r  = qr[2*DATA_W-1:DATA_W];
        if (n[DATA_W-1] ^ d[DATA_W-1]) q = -q;
        if (n[DATA_W-1]) r = -r;
        return {r, q};
    endfunction

    assign a_s    = {{DATA_W{A[DATA_W-1]}}, A};
    assign b_s    = {{DATA_W{B[DATA_W-1]}}, B};
    assign prod_s = a_s * b_s;
    assign prod_u = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};

    always_comb begin
        is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (MDUOp == OP_MADD) || (MDUOp == OP_MSUB);
`endif
        is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    end

    assign accept = start && (state == IDLE);

    // Stage p0: result formed from the operands present at the start edge
    always_comb begin
        res_p0 = '0;
        vld_p0 = 1'b0;
        case (MDUOp)
            OP_MULT:  begin res_p0 = $unsigned(prod_s); vld_p0 = 1'b1;       end
            OP_MULTU: begin res_p0 = prod_u;            vld_p0 = 1'b1;       end
            OP_DIV:   begin res_p0 = div_s(A, B);       vld_p0 = (B != '0);  end
            OP_DIVU:  begin res_p0 = div_u(A, B);       vld_p0 = (B != '0);  end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res_p0 = {HI, LO} + $unsigned(prod_s); vld_p0 = 1'b1; end
            OP_MSUB:  begin res_p0 = {HI, LO} - $unsigned(prod_s); vld_p0 = 1'b1; end
`endif
            default:  ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = BUSY;
                    cnt_nxt   = MUL_CYCLES;
                    load      = 1'b1;
                end else if (accept && is_div) begin
                    state_nxt = BUSY;
                    cnt_nxt   = DIV_CYCLES;
                    load      = 1'b1;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stage p1: pending result held until the completion edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            pend_p1 <= '0;
            vld_p1  <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            busy <= (state_nxt == BUSY);
            if (load) begin
                pend_p1 <= res_p0;
                vld_p1  <= vld_p0;
            end
            if (done && vld_p1) begin
                HI <= pend_p1[2*DATA_W-1:DATA_W];
                LO <= pend_p1[DATA_W-1:0];
            end
            if (accept && (MDUOp == OP_MTHI)) HI <= A;
            if (accept && (MDUOp == OP_MTLO)) LO <= A;
        end
    end

    always_comb begin
        case (MDUOp)
            OP_MFHI: out = HI;
            OP_MFLO: out = LO;
            default: out = '0;
        endcase
    end

endmodule
